// File: rtl/sound_io_pkg.sv
// Shared constants and decode helpers for the Z80 sound I/O block.
package sound_io_pkg;

  // I/O port offsets as seen on SDA[4:0]
  localparam logic [4:0] PORT_CMD       = 5'h00;
  localparam logic [4:0] PORT_YM        = 5'h04;
  localparam logic [4:0] PORT_NMI_EN    = 5'h08;
  localparam logic [4:0] PORT_NMI_DIS   = 5'h18;
  localparam logic [4:0] PORT_REPLY     = 5'h0C;
  localparam logic [4:0] PORT_BANK_BASE = 5'h08;

  // Bank register reset values
  localparam logic [7:0] BANK_16K_RST = 8'h02;
  localparam logic [7:0] BANK_8K_RST  = 8'h06;
  localparam logic [7:0] BANK_4K_RST  = 8'h0E;
  localparam logic [7:0] BANK_2K_RST  = 8'h1E;

  // Bank register index, selected by SDA[1:0] on a bank read
  typedef enum logic [1:0] {
    BANK_IDX_2K  = 2'd0,
    BANK_IDX_4K  = 2'd1,
    BANK_IDX_8K  = 2'd2,
    BANK_IDX_16K = 2'd3
  } bank_idx_e;

  // YM2610 window: SDA[3:2] = 01, SDA[4] and SDA[1:0] free
  function automatic logic is_ym_port(input logic [4:0] port);
    return (port[3:2] == PORT_YM[3:2]);
  endfunction

  // Bank load window: SDA[3:0] = 8..Bh, SDA[4] free
  function automatic logic is_bank_port(input logic [4:0] port);
    return (port[3:2] == PORT_BANK_BASE[3:2]);
  endfunction

  // Reply latch write: SDA[3:0] = Ch, SDA[4] free
  function automatic logic is_reply_port(input logic [4:0] port);
    return (port[3:0] == PORT_REPLY[3:0]);
  endfunction

endpackage

// File: rtl/z80_sound_io_sync_fall_detect.sv
// N-stage synchroniser for an asynchronous active-low level, with a
// one-cycle pulse on each falling edge of the synchronised value.
module sync_fall_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic fall_o
);

  // Anything below two stages is not a synchroniser; clamp it.
  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // Shift chain next state: stage 0 samples the raw input
  always_comb begin
    sync_d = {sync_q[N-2:0], d_i};
  end

  // Synchroniser flops, idle high so reset never looks like an edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {N{1'b1}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // The last stage doubles as edge history for the stage before it,
  // so the pulse is available one stage earlier than a separate
  // history flop would allow.
  assign fall_o = sync_q[N-1] & ~sync_q[N-2];

endmodule

// File: rtl/z80_sound_io.sv
// Z80-side sound I/O: port decode, latch strobes, NMI generation and
// ROM window bank registers, all in the Z80 clock domain.
module z80_sound_io
  import sound_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK_4M,
  input  logic        nRESET,
  input  logic [15:0] SDA,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nM1,
  input  logic        nSDW,
  output logic        nSDZ80R,
  output logic        nSDZ80W,
  output logic        nSDZ80CLR,
  output logic        nYM_CS,
  output logic        nNMI,
  output logic [7:0]  BANK_16K,
  output logic [7:0]  BANK_8K,
  output logic [7:0]  BANK_4K,
  output logic [7:0]  BANK_2K
);

  logic       acc_s;
  logic       rd_s;
  logic       wr_s;
  logic       start_s;
  logic [4:0] port_s;
  logic       sdw_fall_s;
  logic       cmd_taken_s;
  logic       unused_addr_s;

  logic       acc_q;
  logic       nsdz80r_q,   nsdz80r_d;
  logic       nsdz80w_q,   nsdz80w_d;
  logic       nsdz80clr_q, nsdz80clr_d;
  logic       nym_cs_q,    nym_cs_d;
  logic       nmi_en_q,    nmi_en_d;
  logic       nmi_pend_q,  nmi_pend_d;
  logic       nnmi_q,      nnmi_d;
  logic [3:0][7:0] bank_q, bank_d;

  // SDA[7:5] are mirror bits and intentionally ignored
  assign unused_addr_s = ^SDA[7:5];

  // Access qualifier: exactly one of nRD/nWR low, not an interrupt ack
  assign acc_s   = ~nIORQ & nM1 & (nRD ^ nWR);
  assign rd_s    = acc_s & ~nRD;
  assign wr_s    = acc_s & ~nWR;
  assign port_s  = SDA[4:0];
  // One-shot actions fire only on the first edge an access is seen
  assign start_s = acc_s & ~acc_q;

  sync_fall_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sdw_sync (
    .clk_i  (CLK_4M),
    .rst_ni (nRESET),
    .d_i    (nSDW),
    .fall_o (sdw_fall_s)
  );

  // Strobe decode: each strobe follows ACC and its decode with one cycle latency
  always_comb begin
    nsdz80r_d   = ~(rd_s & (port_s == PORT_CMD));
    nsdz80clr_d = ~(wr_s & (port_s == PORT_CMD));
    nym_cs_d    = ~(acc_s & is_ym_port(port_s));
    nsdz80w_d   = ~(wr_s & is_reply_port(port_s));
  end

  // A command is consumed when the read or clear strobe first asserts
  assign cmd_taken_s = (~nsdz80r_d & nsdz80r_q) | (~nsdz80clr_d & nsdz80clr_q);

  // NMI enable, NMI pending and bank register next state
  always_comb begin
    nmi_en_d   = nmi_en_q;
    nmi_pend_d = nmi_pend_q;
    bank_d     = bank_q;
    nnmi_d     = ~(nmi_pend_q & nmi_en_q);

    if (start_s && wr_s && (port_s == PORT_NMI_EN)) begin
      nmi_en_d = 1'b1;
    end else if (start_s && wr_s && (port_s == PORT_NMI_DIS)) begin
      nmi_en_d = 1'b0;
    end else begin
      nmi_en_d = nmi_en_q;
    end

    // A new command beats a simultaneous clear so it is never lost
    if (sdw_fall_s) begin
      nmi_pend_d = 1'b1;
    end else if (cmd_taken_s) begin
      nmi_pend_d = 1'b0;
    end else begin
      nmi_pend_d = nmi_pend_q;
    end

    if (start_s && rd_s && is_bank_port(port_s)) begin
      bank_d[port_s[1:0]] = SDA[15:8];
    end else begin
      bank_d = bank_q;
    end
  end

  // Register file: strobes, NMI state and bank registers
  always_ff @(posedge CLK_4M or negedge nRESET) begin
    if (!nRESET) begin
      acc_q                 <= 1'b0;
      nsdz80r_q             <= 1'b1;
      nsdz80w_q             <= 1'b1;
      nsdz80clr_q           <= 1'b1;
      nym_cs_q              <= 1'b1;
      nmi_en_q              <= 1'b0;
      nmi_pend_q            <= 1'b0;
      nnmi_q                <= 1'b1;
      bank_q[BANK_IDX_2K]   <= BANK_2K_RST;
      bank_q[BANK_IDX_4K]   <= BANK_4K_RST;
      bank_q[BANK_IDX_8K]   <= BANK_8K_RST;
      bank_q[BANK_IDX_16K]  <= BANK_16K_RST;
    end else begin
      acc_q       <= acc_s;
      nsdz80r_q   <= nsdz80r_d;
      nsdz80w_q   <= nsdz80w_d;
      nsdz80clr_q <= nsdz80clr_d;
      nym_cs_q    <= nym_cs_d;
      nmi_en_q    <= nmi_en_d;
      nmi_pend_q  <= nmi_pend_d;
      nnmi_q      <= nnmi_d;
      bank_q      <= bank_d;
    end
  end

  assign nSDZ80R   = nsdz80r_q;
  assign nSDZ80W   = nsdz80w_q;
  assign nSDZ80CLR = nsdz80clr_q;
  assign nYM_CS    = nym_cs_q;
  assign nNMI      = nnmi_q;
  assign BANK_16K  = bank_q[BANK_IDX_16K];
  assign BANK_8K   = bank_q[BANK_IDX_8K];
  assign BANK_4K   = bank_q[BANK_IDX_4K];
  assign BANK_2K   = bank_q[BANK_IDX_2K];

endmodule

// File: tb/tb_z80_sound_io.sv
// Self-checking bench for z80_sound_io: decode table, directed NMI and
// strobe sequences, then random traffic against a reference model.
module tb_z80_sound_io;

  localparam int SYNC = 2;

  logic        CLK_4M = 1'b0;
  logic        nRESET;
  logic [15:0] SDA;
  logic        nIORQ, nRD, nWR, nM1, nSDW;
  logic        nSDZ80R, nSDZ80W, nSDZ80CLR, nYM_CS, nNMI;
  logic [7:0]  BANK_16K, BANK_8K, BANK_4K, BANK_2K;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  z80_sound_io #(.SYNC_STAGES(SYNC)) dut (
    .CLK_4M(CLK_4M), .nRESET(nRESET), .SDA(SDA), .nIORQ(nIORQ), .nRD(nRD),
    .nWR(nWR), .nM1(nM1), .nSDW(nSDW), .nSDZ80R(nSDZ80R), .nSDZ80W(nSDZ80W),
    .nSDZ80CLR(nSDZ80CLR), .nYM_CS(nYM_CS), .nNMI(nNMI), .BANK_16K(BANK_16K),
    .BANK_8K(BANK_8K), .BANK_4K(BANK_4K), .BANK_2K(BANK_2K)
  );

  always #5 CLK_4M = ~CLK_4M;

  // ---------------- reference model ----------------
  // Outputs the Z80 side should show after each clock edge.
  logic       m_r, m_w, m_clr, m_ym, m_nnmi, m_en, m_pend, m_acc;
  logic [7:0] m_bank [4];       // 0:2K 1:4K 2:8K 3:16K
  logic       m_hist [$];       // nSDW as sampled at each past edge

  task automatic model_reset();
    m_r = 1'b1; m_w = 1'b1; m_clr = 1'b1; m_ym = 1'b1; m_nnmi = 1'b1;
    m_en = 1'b0; m_pend = 1'b0; m_acc = 1'b0;
    m_bank[0] = 8'h1E; m_bank[1] = 8'h0E; m_bank[2] = 8'h06; m_bank[3] = 8'h02;
    m_hist = {};
    repeat (SYNC + 1) m_hist.push_back(1'b1);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK_4M or negedge nRESET);
      if (!nRESET) begin
        model_reset();
      end else begin
        logic acc, rd, wr, first, taken, fall;
        logic nr, nw, nclr, nym;
        logic [4:0] p;
        int sz;
        acc  = !nIORQ && nM1 && (nRD != nWR);
        rd   = acc && !nRD;
        wr   = acc && !nWR;
        p    = SDA[4:0];
        nr   = !(rd && p == 5'h00);
        nclr = !(wr && p == 5'h00);
        nw   = !(wr && p[3:0] == 4'hC);
        nym  = !(acc && p[3:2] == 2'b01);
        first = acc && !m_acc;
        taken = (!nr && m_r) || (!nclr && m_clr);
        // A fall on nSDW becomes visible SYNC-1 edges after it is first sampled
        sz   = m_hist.size();
        fall = (m_hist[sz - SYNC] == 1'b1) && (m_hist[sz - SYNC + 1] == 1'b0);
        m_nnmi = !(m_pend && m_en);
        if (fall) m_pend = 1'b1;
        else if (taken) m_pend = 1'b0;
        if (first && wr && p == 5'h08) m_en = 1'b1;
        else if (first && wr && p == 5'h18) m_en = 1'b0;
        if (first && rd && p[3:2] == 2'b10) m_bank[p[1:0]] = SDA[15:8];
        m_hist.push_back(nSDW);
        void'(m_hist.pop_front());
        m_acc = acc; m_r = nr; m_w = nw; m_clr = nclr; m_ym = nym;
      end
    end
  end

  // Every cycle, compare all outputs against the model on the falling edge
  always @(negedge CLK_4M) begin
    if (chk_en) begin
      n_tests++;
      if ({nSDZ80R, nSDZ80W, nSDZ80CLR, nYM_CS, nNMI, BANK_16K, BANK_8K, BANK_4K, BANK_2K} !==
          {m_r, m_w, m_clr, m_ym, m_nnmi, m_bank[3], m_bank[2], m_bank[1], m_bank[0]}) begin
        n_fail++;
        $display("FAIL model t=%0t: got R%b W%b C%b Y%b N%b %h/%h/%h/%h required R%b W%b C%b Y%b N%b %h/%h/%h/%h",
                 $time, nSDZ80R, nSDZ80W, nSDZ80CLR, nYM_CS, nNMI, BANK_16K, BANK_8K, BANK_4K, BANK_2K,
                 m_r, m_w, m_clr, m_ym, m_nnmi, m_bank[3], m_bank[2], m_bank[1], m_bank[0]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_4M);
    #2;
  endtask

  task automatic idle();
    nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1;
  endtask

  task automatic io_rd(input logic [15:0] a);
    SDA = a; nIORQ = 1'b0; nRD = 1'b0; nWR = 1'b1; nM1 = 1'b1;
  endtask

  task automatic io_wr(input logic [15:0] a);
    SDA = a; nIORQ = 1'b0; nRD = 1'b1; nWR = 1'b0; nM1 = 1'b1;
  endtask

  function automatic logic [3:0] strobes();
    return {nSDZ80R, nSDZ80W, nSDZ80CLR, nYM_CS};
  endfunction

  // ---------------- decode table ----------------
  typedef struct {
    logic        niorq, nrd, nwr, nm1;
    logic [15:0] sda;
    logic [3:0]  exp_strb;   // {nSDZ80R, nSDZ80W, nSDZ80CLR, nYM_CS}
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [4:0] ports [10];
    ports = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h18, 5'h1C, 5'h09, 5'h0A, 5'h0B, 5'h13};

    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b0111};  // read cmd
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'b1101};  // write clear
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h00E0, 4'b0111};  // mirror of 00
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0004, 4'b1110};  // YM read
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0017, 4'b1110};  // YM write, SDA[4]=1
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h000C, 4'b1011};  // reply write
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h001C, 4'b1011};  // reply write, SDA[4]=1
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h000C, 4'b1111};  // read of reply port
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b1111};  // nRD and nWR both low
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 4'b1111};  // neither
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b1111};  // interrupt ack
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 4'b1111};  // no IORQ
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0008, 4'b1111};  // NMI enable
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h120A, 4'b1111};  // bank 8K load

    nRESET = 1'b0; nSDW = 1'b1; SDA = 16'h0000; idle();
    repeat (3) tick();
    nRESET = 1'b1;
    tick();
    chk_en = 1'b1;

    // Reset state
    check("rst_banks", {8'h00, BANK_16K, BANK_8K, BANK_4K, BANK_2K}, {8'h00, 32'h02060E1E});
    check("rst_strobes", {36'h0, strobes()}, {36'h0, 4'hF});
    check("rst_nnmi", {39'h0, nNMI}, {39'h0, 1'b1});

    // Bank read held three cycles, address high byte changes mid-access
    io_rd(16'h3A0B); tick();
    check("bank16_load", {8'h00, BANK_16K, BANK_8K, BANK_4K, BANK_2K}, {8'h00, 32'h3A060E1E});
    check("bank_no_strobe", {36'h0, strobes()}, {36'h0, 4'hF});
    SDA = 16'h440B; tick(); tick();
    check("bank_no_retrigger", {32'h0, BANK_16K}, {32'h0, 8'h3A});
    idle(); tick();

    // Enable NMI, then a two-cycle command pulse
    io_wr(16'h0008); tick(); idle(); tick();
    nSDW = 1'b0; tick();
    check("nmi_lat1", {39'h0, nNMI}, {39'h0, 1'b1});
    tick();
    check("nmi_lat2", {39'h0, nNMI}, {39'h0, 1'b1});
    nSDW = 1'b1; tick();
    check("nmi_lat3", {39'h0, nNMI}, {39'h0, 1'b0});

    // Command read clears pending
    io_rd(16'h0000); tick();
    check("cmd_rd_low", {39'h0, nSDZ80R}, {39'h0, 1'b0});
    check("nmi_still_low", {39'h0, nNMI}, {39'h0, 1'b0});
    tick();
    check("nmi_cleared", {39'h0, nNMI}, {39'h0, 1'b1});
    idle(); tick();
    check("cmd_rd_release", {39'h0, nSDZ80R}, {39'h0, 1'b1});

    // Disable and re-enable while pending
    nSDW = 1'b0; tick(); tick(); nSDW = 1'b1; tick();
    check("nmi_pend2", {39'h0, nNMI}, {39'h0, 1'b0});
    io_wr(16'h0018); tick(); idle(); tick();
    check("nmi_disabled", {39'h0, nNMI}, {39'h0, 1'b1});
    tick();
    io_wr(16'h0008); tick(); idle(); tick();
    check("nmi_reenabled", {39'h0, nNMI}, {39'h0, 1'b0});

    // Clear pending, then make a new command collide with the read
    io_rd(16'h0000); tick(); idle(); tick(); tick();
    check("nmi_idle", {39'h0, nNMI}, {39'h0, 1'b1});
    nSDW = 1'b0; tick();
    io_rd(16'h0000); tick();
    check("collide_rd", {39'h0, nSDZ80R}, {39'h0, 1'b0});
    idle(); nSDW = 1'b1; tick();
    check("collide_set_wins", {39'h0, nNMI}, {39'h0, 1'b0});
    tick();
    check("collide_hold", {39'h0, nNMI}, {39'h0, 1'b0});
    io_rd(16'h0000); tick(); idle(); tick();

    // Reply write held three cycles
    io_wr(16'h550C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reply_low", {39'h0, nSDZ80W}, {39'h0, 1'b0});
    end
    idle(); tick();
    check("reply_release", {39'h0, nSDZ80W}, {39'h0, 1'b1});

    // Interrupt acknowledge is never decoded
    SDA = 16'h0000; nIORQ = 1'b0; nM1 = 1'b0; nRD = 1'b1; nWR = 1'b1; tick();
    check("inta_none", {36'h0, strobes()}, {36'h0, 4'hF});
    idle(); tick();

    // Reset asserted mid-access
    io_rd(16'h0000); tick();
    check("pre_rst_rd", {39'h0, nSDZ80R}, {39'h0, 1'b0});
    #1 nRESET = 1'b0;
    #1;
    check("async_rst_strobes", {36'h0, strobes()}, {36'h0, 4'hF});
    check("async_rst_banks", {8'h00, BANK_16K, BANK_8K, BANK_4K, BANK_2K}, {8'h00, 32'h02060E1E});
    idle(); tick();
    nRESET = 1'b1; tick();

    // Decode table
    for (int i = 0; i < 14; i++) begin
      SDA = vecs[i].sda; nIORQ = vecs[i].niorq; nRD = vecs[i].nrd;
      nWR = vecs[i].nwr; nM1 = vecs[i].nm1;
      tick();
      check($sformatf("table%0d", i), {36'h0, strobes()}, {36'h0, vecs[i].exp_strb});
      idle(); tick();
    end

    // Random traffic, checked every cycle by the model
    for (int n = 0; n < 800; n++) begin
      int gap, len, kind;
      logic [4:0] p;
      gap  = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 7) == 0) nSDW = ~nSDW;
        idle(); tick();
      end
      p    = ports[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) p = 5'($urandom);
      SDA  = {8'($urandom), 3'($urandom), p};
      kind = $urandom_range(0, 9);
      nIORQ = 1'b0; nM1 = 1'b1;
      if (kind < 4) begin nRD = 1'b0; nWR = 1'b1; end
      else if (kind < 8) begin nRD = 1'b1; nWR = 1'b0; end
      else if (kind == 8) begin nRD = 1'b0; nWR = 1'b0; end
      else begin nM1 = 1'b0; nRD = 1'($urandom); nWR = 1'b1; end
      len = $urandom_range(1, 4);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0) nSDW = ~nSDW;
        tick();
      end
    end
    idle(); nSDW = 1'b1; tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
